// File: rtl/sad_pkg.sv
// Shared definitions for the SAD minimum tracker.
// Holds the controller state type, default lane widths and helpers that
// locate one lane inside a packed multi-lane bus.
package sad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int SAD_W_DEF = 14;
  localparam int IDX_W_DEF = 10;

  // Lowest bit of lane 'lane' in a bus packed with 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Highest bit of lane 'lane' in a bus packed with 'width'-bit lanes.
  function automatic int lane_hi(input int lane, input int width);
    return lane * width + width - 1;
  endfunction

endpackage

// File: rtl/sad_min_lane.sv
// One partition lane of the SAD minimum tracker.
// Keeps the smallest SAD seen since the last clear and the candidate index
// at which it was taken. A strict compare keeps the earliest candidate on ties,
// and the all-ones clear value can never be replaced by an all-ones SAD.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clear           reload minimum to all-ones and index to zero
//   en              a candidate is accepted this cycle
//   sad, idx        candidate SAD for this lane and its index
//   min_sad,min_idx current minimum and its index
module sad_min_lane
  import sad_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [SAD_W-1:0] sad,
  input  logic [IDX_W-1:0] idx,
  output logic [SAD_W-1:0] min_sad,
  output logic [IDX_W-1:0] min_idx
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      min_sad <= '1;
      min_idx <= '0;
    end else if (en && (sad < min_sad)) begin
      min_sad <= sad;
      min_idx <= idx;
    end
  end

endmodule

// File: rtl/sad_min_track.sv
// SAD minimum tracker: follows the per-partition minimum SAD and its
// candidate index over a search of N_CAND candidates.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              begin (or restart) a search, clears all minima
//   sad_valid          sad_in / cand_idx carry a candidate this cycle
//   sad_in             packed lane SADs, lane p at [p*SAD_W +: SAD_W]
//   cand_idx           index of the presented candidate
//   min_sad, min_idx   per-lane minimum and index, same packing
//   cand_cnt           candidates accepted in the current search
//   busy               search in progress
//   done               one-cycle pulse when results are final
//
// state     | meaning
// ST_IDLE   | waiting for start, previous results held
// ST_SEARCH | accepting candidates
// ST_DONE   | last candidate taken, results final for one cycle
module sad_min_track
  import sad_pkg::*;
#(
  parameter int N_PART = 8,
  parameter int SAD_W  = SAD_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int N_CAND = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sad_valid,
  input  logic [N_PART*SAD_W-1:0] sad_in,
  input  logic [IDX_W-1:0]        cand_idx,
  output logic [N_PART*SAD_W-1:0] min_sad,
  output logic [N_PART*IDX_W-1:0] min_idx,
  output logic [IDX_W:0]          cand_cnt,
  output logic                    busy,
  output logic                    done
);

  // Count value held while the final candidate is presented.
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(N_CAND - 1);

  state_t state, state_nxt;
  logic   lane_clr;
  logic   lane_en;

  always_comb begin
    state_nxt = state;
    lane_clr  = 1'b0;
    lane_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SEARCH;
          lane_clr  = 1'b1;
        end
      end
      ST_SEARCH: begin
        // A restart discards any candidate presented in the same cycle.
        if (start) begin
          lane_clr = 1'b1;
        end else if (sad_valid) begin
          lane_en = 1'b1;
          if (cand_cnt == CNT_LAST) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        lane_clr  = start;
        state_nxt = start ? ST_SEARCH : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cand_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_SEARCH);
      done  <= (state_nxt == ST_DONE);
      if (lane_clr)     cand_cnt <= '0;
      else if (lane_en) cand_cnt <= cand_cnt + (IDX_W+1)'(1);
    end
  end

  for (genvar p = 0; p < N_PART; p++) begin : g_lane
    sad_min_lane #(
      .SAD_W (SAD_W),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (lane_clr),
      .en      (lane_en),
      .sad     (sad_in[lane_hi(p, SAD_W):lane_lo(p, SAD_W)]),
      .idx     (cand_idx),
      .min_sad (min_sad[lane_hi(p, SAD_W):lane_lo(p, SAD_W)]),
      .min_idx (min_idx[lane_hi(p, IDX_W):lane_lo(p, IDX_W)])
    );
  end

endmodule

// File: tb/tb_sad_min_track.sv
module tb_sad_min_track;

  localparam int NP = 2;
  localparam int SW = 14;
  localparam int IW = 10;
  localparam int NC = 4;
  localparam logic [SW-1:0] ONES = '1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sad_valid;
  logic [NP*SW-1:0] sad_in;
  logic [IW-1:0]    cand_idx;
  logic [NP*SW-1:0] min_sad;
  logic [NP*IW-1:0] min_idx;
  logic [IW:0]      cand_cnt;
  logic             busy;
  logic             done;

  // Second instance with a single-candidate search.
  logic             start1;
  logic             valid1;
  logic [SW-1:0]    sad1;
  logic [IW-1:0]    idx1;
  logic [SW-1:0]    min_sad1;
  logic [IW-1:0]    min_idx1;
  logic [IW:0]      cnt1;
  logic             busy1;
  logic             done1;

  sad_min_track #(.N_PART(NP), .SAD_W(SW), .IDX_W(IW), .N_CAND(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sad_valid(sad_valid),
    .sad_in(sad_in), .cand_idx(cand_idx), .min_sad(min_sad), .min_idx(min_idx),
    .cand_cnt(cand_cnt), .busy(busy), .done(done)
  );

  sad_min_track #(.N_PART(1), .SAD_W(SW), .IDX_W(IW), .N_CAND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sad_valid(valid1),
    .sad_in(sad1), .cand_idx(idx1), .min_sad(min_sad1), .min_idx(min_idx1),
    .cand_cnt(cnt1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: search phase plus the list of candidates accepted
  // since the last clear; minima are recomputed from that list.
  int m_phase;  // 0 idle, 1 searching, 2 finished
  int m_cnt;
  int m_hist_sad [NP][NC];
  int m_hist_idx [NC];

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic s, input logic v,
                              input logic [SW-1:0] a, input logic [SW-1:0] b,
                              input logic [IW-1:0] ix);
    if (!r) begin
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: if (s) begin m_phase = 1; m_cnt = 0; end
        1: begin
          if (s) m_cnt = 0;
          else if (v) begin
            m_hist_sad[0][m_cnt] = int'(a);
            m_hist_sad[1][m_cnt] = int'(b);
            m_hist_idx[m_cnt]    = int'(ix);
            m_cnt++;
            if (m_cnt == NC) m_phase = 2;
          end
        end
        default: begin
          if (s) begin m_phase = 1; m_cnt = 0; end
          else m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic model_check();
    int m, mi;
    check("busy", 32'(busy), (m_phase == 1) ? 1 : 0);
    check("done", 32'(done), (m_phase == 2) ? 1 : 0);
    check("cand_cnt", 32'(cand_cnt), m_cnt);
    for (int l = 0; l < NP; l++) begin
      m  = int'(ONES);
      mi = 0;
      for (int k = 0; k < m_cnt; k++)
        if (m_hist_sad[l][k] < m) begin
          m  = m_hist_sad[l][k];
          mi = m_hist_idx[k];
        end
      check($sformatf("min_sad[%0d]", l), 32'(min_sad[l*SW +: SW]), m);
      check($sformatf("min_idx[%0d]", l), 32'(min_idx[l*IW +: IW]), mi);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later.
  task automatic drive(input logic r, input logic s, input logic v,
                       input logic [SW-1:0] a, input logic [SW-1:0] b,
                       input logic [IW-1:0] ix);
    rst_n     = r;
    start     = s;
    sad_valid = v;
    sad_in    = {b, a};
    cand_idx  = ix;
    @(posedge clk);
    model_update(r, s, v, a, b, ix);
    #1;
    model_check();
  endtask

  typedef struct {
    logic r, s, v;
    logic [SW-1:0] a, b;
    logic [IW-1:0] ix;
    logic eb, ed;
    int ec;
    logic [SW-1:0] em0, em1;
    logic [IW-1:0] ei0, ei1;
  } vec_t;

  vec_t tbl [8];
  int   done_seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; sad_valid = 1'b0; sad_in = '0; cand_idx = '0;
    start1 = 1'b0; valid1 = 1'b0; sad1 = '0; idx1 = '0;
    m_phase = 0; m_cnt = 0;

    //          r  s  v   a    b   ix  busy done cnt min0 min1 idx0 idx1
    tbl[0] = '{1'b0,1'b1,1'b1, 14'd7,  14'd7, 10'd3, 1'b0,1'b0,0, ONES, ONES, 10'd0,10'd0};
    tbl[1] = '{1'b1,1'b1,1'b0, 14'd0,  14'd0, 10'd0, 1'b1,1'b0,0, ONES, ONES, 10'd0,10'd0};
    tbl[2] = '{1'b1,1'b0,1'b1, 14'd50, 14'd9, 10'd0, 1'b1,1'b0,1, 14'd50,14'd9, 10'd0,10'd0};
    tbl[3] = '{1'b1,1'b0,1'b1, 14'd30, 14'd8, 10'd1, 1'b1,1'b0,2, 14'd30,14'd8, 10'd1,10'd1};
    tbl[4] = '{1'b1,1'b0,1'b1, 14'd30, 14'd7, 10'd2, 1'b1,1'b0,3, 14'd30,14'd7, 10'd1,10'd2};
    tbl[5] = '{1'b1,1'b0,1'b1, 14'd40, 14'd6, 10'd3, 1'b0,1'b1,4, 14'd30,14'd6, 10'd1,10'd3};
    tbl[6] = '{1'b1,1'b0,1'b0, 14'd0,  14'd0, 10'd0, 1'b0,1'b0,4, 14'd30,14'd6, 10'd1,10'd3};
    tbl[7] = '{1'b1,1'b0,1'b1, 14'd1,  14'd1, 10'd2, 1'b0,1'b0,4, 14'd30,14'd6, 10'd1,10'd3};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].ix);
      check($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].eb));
      check($sformatf("tbl%0d done", i), 32'(done), 32'(tbl[i].ed));
      check($sformatf("tbl%0d cnt", i), 32'(cand_cnt), tbl[i].ec);
      check($sformatf("tbl%0d min0", i), 32'(min_sad[SW-1:0]), 32'(tbl[i].em0));
      check($sformatf("tbl%0d min1", i), 32'(min_sad[2*SW-1:SW]), 32'(tbl[i].em1));
      check($sformatf("tbl%0d idx0", i), 32'(min_idx[IW-1:0]), 32'(tbl[i].ei0));
      check($sformatf("tbl%0d idx1", i), 32'(min_idx[2*IW-1:IW]), 32'(tbl[i].ei1));
    end

    // Lane1 descending SADs with two idle cycles between candidates.
    drive(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < NC; k++) begin
      drive(1, 0, 1, 14'd100, 14'(9 - k), 10'(k));
      if (k < NC - 1) begin
        drive(1, 0, 0, 14'(k), 14'(k), 10'(7));
        check("gap busy", 32'(busy), 1);
        drive(1, 0, 0, 14'(k), 14'(k), 10'(7));
      end
    end
    check("gap done", 32'(done), 1);
    check("gap min1", 32'(min_sad[2*SW-1:SW]), 6);
    check("gap idx1", 32'(min_idx[2*IW-1:IW]), 3);
    check("gap cnt", 32'(cand_cnt), 4);
    drive(1, 0, 0, 0, 0, 0);

    // Restart after two candidates, the restart-cycle candidate is dropped.
    done_seen = 0;
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 14'd5, 14'd5, 10'd0);
    drive(1, 0, 1, 14'd5, 14'd5, 10'd1);
    drive(1, 1, 1, 14'd1, 14'd1, 10'd9);
    done_seen += int'(done);
    for (int k = 0; k < NC; k++) begin
      drive(1, 0, 1, 14'(20 + k), 14'(20 + k), 10'(10 + k));
      done_seen += int'(done);
    end
    check("restart min0", 32'(min_sad[SW-1:0]), 20);
    check("restart idx0", 32'(min_idx[IW-1:0]), 10);
    drive(1, 0, 0, 0, 0, 0);
    done_seen += int'(done);
    check("restart done count", 32'(done_seen), 1);

    // Reset in the middle of a search.
    drive(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(1, 0, 1, 14'(3 + k), 14'(4 + k), 10'(k));
    drive(0, 1, 1, 14'd1, 14'd1, 10'd5);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst min0", 32'(min_sad[SW-1:0]), 32'(ONES));
    check("rst cnt", 32'(cand_cnt), 0);
    drive(1, 0, 0, 0, 0, 0);
    check("rst no done", 32'(done), 0);

    // Candidate presented in idle is ignored.
    drive(1, 0, 1, 14'd1, 14'd1, 10'd2);
    drive(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < NC; k++) drive(1, 0, 1, 14'd100, 14'd100, 10'(k));
    check("idle ign min0", 32'(min_sad[SW-1:0]), 100);
    check("idle ign idx0", 32'(min_idx[IW-1:0]), 0);

    // Single-candidate instance with an all-ones SAD.
    start1 = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    check("nc1 busy", 32'(busy1), 1);
    start1 = 1'b0; valid1 = 1'b1; sad1 = ONES; idx1 = 10'd5;
    drive(1, 0, 0, 0, 0, 0);
    valid1 = 1'b0;
    check("nc1 done", 32'(done1), 1);
    check("nc1 min", 32'(min_sad1), 32'(ONES));
    check("nc1 idx", 32'(min_idx1), 0);
    check("nc1 cnt", 32'(cnt1), 1);
    drive(1, 0, 0, 0, 0, 0);
    check("nc1 done end", 32'(done1), 0);
    check("nc1 busy end", 32'(busy1), 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic r, s, v;
      logic [SW-1:0] a, b;
      r = ($urandom_range(0, 79) != 0);
      s = ($urandom_range(0, 14) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? ONES : 14'($urandom_range(0, 40));
      b = ($urandom_range(0, 7) == 0) ? ONES : 14'($urandom_range(0, 40));
      drive(r, s, v, a, b, 10'($urandom_range(0, 1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
